// File: rtl/sync_fifo_arb_pkg.sv
// sync_fifo_arb_pkg: shared types, widths and helpers for the sync_fifo write arbiter.
// Contents:
//   arb_state_t - arbiter FSM state (IDLE: no grant, BURST: grant active)
//   CNT_W       - width of the burst length / burst counter (matches cfg_burst)
//   rr_next     - round-robin successor of a requester index
package sync_fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int CNT_W = 4;

    function automatic int rr_next(input int ptr, input int nreq);
        return (ptr + 1) % nreq;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Ports:
//   req_i  - request vector, one bit per requester
//   ptr_i  - index with highest priority this round
//   pick_o - first set request at or after ptr_i, wrapping
//   any_o  - at least one request is set
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   pick_o,
    output logic            any_o
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset back to ptr_i so the nearest set bit wins.
    always_comb begin
        pick_o = '0;
        idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx    = IW'((int'(ptr_i) + k) % NREQ);
            pick_o = req_i[idx] ? idx : pick_o;
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and fall-through read data.
// Ports:
//   clk, rst_n - clock, asynchronous active-high reset
//   wr_i       - write strobe (ignored when full), wr_dat_i write data
//   rd_i       - read strobe (ignored when empty), rd_dat_o head-of-queue data
//   num_o      - occupancy 0..DEEP, full_o / empty_o status flags
module sync_fifo #(
    parameter int BITWID  = 5,
    parameter int DEEPWID = 3,
    parameter int DEEP    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_i,
    input  logic [BITWID-1:0] wr_dat_i,
    input  logic              rd_i,
    output logic [BITWID-1:0] rd_dat_o,
    output logic [DEEPWID:0]  num_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [BITWID-1:0]  mem_q [DEEP];
    logic [DEEPWID-1:0] wptr_q, rptr_q;
    logic [DEEPWID:0]   num_q;
    logic               we, re;

    assign full_o   = num_q == (DEEPWID+1)'(DEEP);
    assign empty_o  = num_q == '0;
    assign we       = wr_i && !full_o;
    assign re       = rd_i && !empty_o;
    assign rd_dat_o = mem_q[rptr_q];
    assign num_o    = num_q;

    always_ff @(posedge clk)
        if (we) mem_q[wptr_q] <= wr_dat_i;

    // Pointers wrap naturally because DEEP == 2**DEEPWID.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            num_q  <= '0;
        end else begin
            wptr_q <= wptr_q + DEEPWID'(we);
            rptr_q <= rptr_q + DEEPWID'(re);
            num_q  <= num_q + (DEEPWID+1)'(we) - (DEEPWID+1)'(re);
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// sync_fifo_wr_arb: round-robin burst arbiter sharing one sync_fifo write port among NREQ producers.
// Ports:
//   clk, rst_n  - clock, asynchronous active-high reset (asserted when rst_n=1)
//   req_vld     - per-requester valid; req_dat holds requester i at [i*BITWID +: BITWID]
//   req_rdy     - per-requester ready (combinational, only the granted bit can be set)
//   cfg_burst   - max words per grant, 0 treated as 1, sampled when a grant starts
//   fifo_num    - FIFO occupancy from sync_fifo
//   fifo_wr     - registered FIFO write strobe, fifo_wr_dat its data
//   grant_vld   - grant active, grant_id current or last granted requester
module sync_fifo_wr_arb
    import sync_fifo_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int BITWID  = 5,
    parameter int DEEPWID = 3,
    parameter int DEEP    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_vld,
    input  logic [NREQ*BITWID-1:0]   req_dat,
    output logic [NREQ-1:0]          req_rdy,
    input  logic [3:0]               cfg_burst,
    input  logic [DEEPWID:0]         fifo_num,
    output logic                     fifo_wr,
    output logic [BITWID-1:0]        fifo_wr_dat,
    output logic                     grant_vld,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int IW = $clog2(NREQ);

    arb_state_t        state_q;
    logic [IW-1:0]     rr_ptr_q, grant_id_q, pick;
    logic [CNT_W-1:0]  burst_len_q, burst_cnt_q, burst_len_d;
    logic              fifo_wr_q;
    logic [BITWID-1:0] fifo_wr_dat_q;
    logic              any, in_burst, space_ok, xfer, last;
    logic [DEEPWID+1:0] occ;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i  (req_vld),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick),
        .any_o  (any)
    );

    // The registered write is captured by the FIFO this edge but not yet in fifo_num.
    assign occ         = {1'b0, fifo_num} + (DEEPWID+2)'(fifo_wr_q);
    assign space_ok    = occ < (DEEPWID+2)'(DEEP);
    assign in_burst    = state_q == BURST;
    assign req_rdy     = (in_burst && space_ok) ? NREQ'(1) << grant_id_q : '0;
    assign xfer        = in_burst && req_vld[grant_id_q] && space_ok;
    assign last        = xfer && (burst_cnt_q + CNT_W'(1) == burst_len_q);
    assign burst_len_d = (cfg_burst == '0) ? CNT_W'(1) : cfg_burst;

    assign fifo_wr     = fifo_wr_q;
    assign fifo_wr_dat = fifo_wr_dat_q;
    assign grant_vld   = in_burst;
    assign grant_id    = grant_id_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            burst_len_q   <= '0;
            burst_cnt_q   <= '0;
            fifo_wr_q     <= 1'b0;
            fifo_wr_dat_q <= '0;
        end else begin
            fifo_wr_q <= xfer;
            if (xfer) fifo_wr_dat_q <= req_dat[grant_id_q*BITWID +: BITWID];
            if (state_q == IDLE) begin
                if (any) begin
                    state_q     <= BURST;
                    grant_id_q  <= pick;
                    burst_len_q <= burst_len_d;
                    burst_cnt_q <= '0;
                end
            end else if (last || !req_vld[grant_id_q]) begin
                state_q  <= IDLE;
                rr_ptr_q <= IW'(rr_next(int'(grant_id_q), NREQ));
            end else if (xfer) begin
                burst_cnt_q <= burst_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
